// File: rtl/fir_mode_sequencer.sv
// fir_mode_sequencer
// Sits in front of an external FIR filter whose delay line shifts every clock.
// It passes accepted samples to the filter, or zero bubbles when nothing is
// accepted. It sequences LP/HP mode changes: the delay line is first flushed
// with zeros so that no output ever mixes samples taken in two modes. It also
// tags every filter result with the mode the result was computed in.
module fir_mode_sequencer #(
    parameter int DW   = 16,
    parameter int YW   = 32,
    parameter int TAPS = 4,
    parameter int LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    input  logic                 mode_req_valid,
    input  logic                 mode_req,
    output logic                 mode_req_ready,
    output logic                 mode_ack,
    output logic                 fir_mode,
    output logic signed [DW-1:0] fir_x_in,
    input  logic signed [YW-1:0] fir_y_in,
    output logic                 out_valid,
    output logic signed [YW-1:0] out_data,
    output logic                 out_mode,
    output logic                 busy
);

    // Flush length covers every tap plus the filter pipeline, so the last
    // pre-switch result has left the filter before the mode input changes.
    localparam int             CW        = $clog2(TAPS + LAT + 1);
    localparam logic [CW-1:0]  FLUSH_LEN = CW'(TAPS + LAT);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FLUSH  = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  fir_mode_r;
    logic                  pending_mode_r;
    logic [CW-1:0]         flush_cnt_r;
    logic [LAT-1:0]        trk_valid_r;
    logic [LAT-1:0]        trk_mode_r;
    logic                  out_valid_r;
    logic signed [YW-1:0]  out_data_r;
    logic                  out_mode_r;
    logic                  mode_ack_r;

    logic                  run_s;
    logic                  in_ready_s;
    logic                  req_ready_s;
    logic                  busy_s;
    logic                  sample_acc_s;
    logic                  req_acc_s;
    logic                  req_switch_s;
    logic                  req_same_s;
    logic signed [DW-1:0]  fir_x_s;

    // Handshake and filter-input decode; every handshake is forced low while
    // reset is asserted so nothing is accepted by a block held in reset.
    always_comb begin
        run_s        = 1'b0;
        in_ready_s   = 1'b0;
        req_ready_s  = 1'b0;
        busy_s       = 1'b0;
        sample_acc_s = 1'b0;
        req_acc_s    = 1'b0;
        req_switch_s = 1'b0;
        req_same_s   = 1'b0;
        fir_x_s      = {DW{1'b0}};
        if (state_r == ST_RUN) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
        in_ready_s   = reset_n & run_s;
        req_ready_s  = reset_n & run_s;
        busy_s       = reset_n & ~run_s;
        sample_acc_s = in_valid & in_ready_s;
        req_acc_s    = mode_req_valid & req_ready_s;
        req_switch_s = req_acc_s & (mode_req != fir_mode_r);
        req_same_s   = req_acc_s & (mode_req == fir_mode_r);
        if (sample_acc_s) begin
            fir_x_s = in_data;
        end else begin
            fir_x_s = {DW{1'b0}};
        end
    end

    // Next-state logic: RUN -> FLUSH on a real mode change, FLUSH counts the
    // delay line empty, SWITCH is a single cycle in which the mode flips.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (req_switch_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_SWITCH: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Flush down-counter: loaded when the flush is decided and counted down
    // to one during FLUSH; it never wraps below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt_r <= CNT_ZERO;
        end else if (req_switch_s) begin
            flush_cnt_r <= FLUSH_LEN;
        end else if ((state_r == ST_FLUSH) && (flush_cnt_r != CNT_ZERO)) begin
            flush_cnt_r <= flush_cnt_r - CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Pending mode is captured on the accepting cycle, so the requester may
    // change mode_req afterwards without affecting the switch in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_mode_r <= 1'b0;
        end else if (req_switch_s) begin
            pending_mode_r <= mode_req;
        end else begin
            pending_mode_r <= pending_mode_r;
        end
    end

    // Filter mode only changes at the end of SWITCH, when the delay line is
    // known to hold nothing but zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fir_mode_r <= 1'b0;
        end else if (state_r == ST_SWITCH) begin
            fir_mode_r <= pending_mode_r;
        end else begin
            fir_mode_r <= fir_mode_r;
        end
    end

    // Acknowledge pulse: after SWITCH, or directly after a request for the
    // mode that is already active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_ack_r <= 1'b0;
        end else begin
            mode_ack_r <= (state_r == ST_SWITCH) | req_same_s;
        end
    end

    // Result tracker: follows each filter input through the filter latency,
    // recording whether it was a real sample and which mode it met.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_valid_r <= {LAT{1'b0}};
            trk_mode_r  <= {LAT{1'b0}};
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                trk_valid_r[i] <= trk_valid_r[i-1];
                trk_mode_r[i]  <= trk_mode_r[i-1];
            end
            trk_valid_r[0] <= sample_acc_s;
            trk_mode_r[0]  <= fir_mode_r;
        end
    end

    // Output stage: captures the filter result belonging to a real sample;
    // bubbles leave out_data untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {YW{1'b0}};
            out_mode_r  <= 1'b0;
        end else if (trk_valid_r[LAT-1]) begin
            out_valid_r <= 1'b1;
            out_data_r  <= fir_y_in;
            out_mode_r  <= trk_mode_r[LAT-1];
        end else begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_mode_r  <= out_mode_r;
        end
    end

    assign in_ready       = in_ready_s;
    assign mode_req_ready = req_ready_s;
    assign busy           = busy_s;
    assign fir_x_in       = fir_x_s;
    assign fir_mode       = fir_mode_r;
    assign mode_ack       = mode_ack_r;
    assign out_valid      = out_valid_r;
    assign out_data       = out_data_r;
    assign out_mode       = out_mode_r;

endmodule

// File: tb/tb_fir_mode_sequencer.sv
// Bench for fir_mode_sequencer: a stand-in FIR filter plus a history-based
// reference. The reference is a per-cycle record of what the filter should
// have been fed, together with the cycle-number schedule of busy windows,
// mode flips and acknowledge pulses.
module tb_fir_mode_sequencer;

    localparam int DW   = 16;
    localparam int YW   = 32;
    localparam int TAPS = 4;
    localparam int LAT  = 1;
    localparam int HMAX = 4096;

    logic                 clk;
    logic                 reset_n;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 mode_req_valid;
    logic                 mode_req;
    logic                 mode_req_ready;
    logic                 mode_ack;
    logic                 fir_mode;
    logic signed [DW-1:0] fir_x_in;
    logic signed [YW-1:0] fir_y_in;
    logic                 out_valid;
    logic signed [YW-1:0] out_data;
    logic                 out_mode;
    logic                 busy;

    fir_mode_sequencer #(.DW(DW), .YW(YW), .TAPS(TAPS), .LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mode_req_valid(mode_req_valid), .mode_req(mode_req),
        .mode_req_ready(mode_req_ready), .mode_ack(mode_ack),
        .fir_mode(fir_mode), .fir_x_in(fir_x_in), .fir_y_in(fir_y_in),
        .out_valid(out_valid), .out_data(out_data), .out_mode(out_mode),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter coefficients: LP = all ones, HP = alternating signs.
    function automatic int coef(input int k, input bit m);
        if (m && (k % 2 == 1)) return -1;
        return 1;
    endfunction

    // ---------------- stand-in filter (latency 1) ----------------
    logic signed [DW-1:0] ftap [0:TAPS-2];
    logic signed [YW-1:0] fy_r;

    function automatic int filt_sum();
        int s;
        s = int'(fir_x_in) * coef(0, fir_mode);
        for (int k = 1; k < TAPS; k++) s += int'(ftap[k-1]) * coef(k, fir_mode);
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS - 1; k++) ftap[k] <= '0;
            fy_r <= '0;
        end else begin
            fy_r    <= filt_sum();
            ftap[0] <= fir_x_in;
            for (int k = 1; k < TAPS - 1; k++) ftap[k] <= ftap[k-1];
        end
    end
    assign fir_y_in = fy_r;

    // ---------------- reference model state ----------------
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  x_hist    [0:HMAX-1];
    bit  acc_hist  [0:HMAX-1];
    bit  mode_hist [0:HMAX-1];
    bit  m_mode;
    bit  pend_mode;
    int  busy_end;
    int  flip_at;
    int  ack_at;
    int  exp_data;
    bit  exp_omode;
    bit  last_racc;
    bit  hold_v;
    bit  hold_m;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected filter output for the sample fed in cycle a.
    function automatic int exp_y(input int a);
        int s;
        s = 0;
        for (int k = 0; k < TAPS; k++)
            if (a - k >= 0) s += x_hist[a-k] * coef(k, mode_hist[a]);
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < HMAX; i++) begin
            x_hist[i] = 0; acc_hist[i] = 1'b0; mode_hist[i] = 1'b0;
        end
        m_mode = 1'b0; pend_mode = 1'b0;
        busy_end = -1; flip_at = -1; ack_at = -1;
        exp_data = 0; exp_omode = 1'b0; hold_v = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, advance model.
    task automatic step(input bit iv, input logic signed [DW-1:0] id, input bit rv, input bit rm);
        bit e_busy, e_rdy, acc, racc, e_ov;
        @(negedge clk);
        in_valid = iv; in_data = id; mode_req_valid = rv; mode_req = rm;
        if (cyc == flip_at) m_mode = pend_mode;
        e_busy = (cyc <= busy_end);
        e_rdy  = !e_busy;
        acc    = iv && e_rdy;
        racc   = rv && e_rdy;
        e_ov   = 1'b0;
        if (cyc >= 2) e_ov = acc_hist[cyc-2];
        if (e_ov) begin
            exp_data  = exp_y(cyc - 2);
            exp_omode = mode_hist[cyc-2];
        end
        #1;
        check_eq("in_ready", in_ready, e_rdy);
        check_eq("mode_req_ready", mode_req_ready, e_rdy);
        check_eq("busy", busy, e_busy);
        check_eq("fir_x_in", fir_x_in, acc ? id : 16'sd0);
        check_eq("fir_mode", fir_mode, m_mode);
        check_eq("mode_ack", mode_ack, cyc == ack_at);
        check_eq("out_valid", out_valid, e_ov);
        check_eq("out_data", out_data, exp_data);
        if (e_ov) check_eq("out_mode", out_mode, exp_omode);
        x_hist[cyc]    = acc ? int'(id) : 0;
        acc_hist[cyc]  = acc;
        mode_hist[cyc] = m_mode;
        if (racc) begin
            if (rm == m_mode) begin
                ack_at = cyc + 1;
            end else begin
                pend_mode = rm;
                busy_end  = cyc + TAPS + LAT + 1;
                flip_at   = cyc + TAPS + LAT + 2;
                ack_at    = cyc + TAPS + LAT + 2;
            end
        end
        last_racc = racc;
        cyc++;
    endtask

    // Asserts reset at the current time, checks reset values at once, releases.
    task automatic apply_reset(input bit iv);
        in_valid = iv; in_data = 16'sd1111; mode_req_valid = iv; mode_req = 1'b1;
        reset_n = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_mode_req_ready", mode_req_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_fir_x_in", fir_x_in, 16'sd0);
        check_eq("rst_fir_mode", fir_mode, 1'b0);
        check_eq("rst_mode_ack", mode_ack, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 32'sd0);
        check_eq("rst_out_mode", out_mode, 1'b0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0; in_data = 16'sd0; mode_req_valid = 1'b0; mode_req = 1'b0;
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        int cnt_a, cnt_b;
        bit got;
        logic signed [DW-1:0] rd;
        reset_n = 1'b1; in_valid = 1'b0; in_data = 16'sd0;
        mode_req_valid = 1'b0; mode_req = 1'b0;
        model_clear();
        #2;
        apply_reset(1'b0);

        // LP stream: 2000 x4 then 0
        for (int i = 0; i < 4; i++) step(1'b1, 16'sd2000, 1'b0, 1'b0);
        step(1'b1, 16'sd0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 16'sd0, 1'b0, 1'b0);

        // HP request together with sample 2000; samples offered during flush are refused
        step(1'b1, 16'sd2000, 1'b1, 1'b1);
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'sd1234, 1'b0, 1'b0);
            if (busy) cnt_a++;
        end
        check_eq("busy_cycles", cnt_a, 6);
        check_eq("fir_mode_after_hp", fir_mode, 1'b1);

        // Request for the mode already active
        step(1'b1, 16'sd5, 1'b1, 1'b1);
        step(1'b0, 16'sd0, 1'b0, 1'b0);

        // Second request held through the first switch
        cnt_b = 0;
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b0, 16'sd0, 1'b1, 1'b1);
            if (mode_ack) cnt_b++;
            got = last_racc;
        end
        check_eq("held_req_accepted", got, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 16'sd0, 1'b0, 1'b0);
            if (mode_ack) cnt_b++;
        end
        check_eq("ack_count", cnt_b, 2);

        // Reset during the third FLUSH cycle aborts the switch
        step(1'b1, 16'sd300, 1'b1, 1'b0);
        step(1'b0, 16'sd0, 1'b0, 1'b0);
        step(1'b0, 16'sd0, 1'b0, 1'b0);
        @(negedge clk);
        apply_reset(1'b1);
        repeat (8) step(1'b0, 16'sd0, 1'b0, 1'b0);

        // LP request while already LP
        step(1'b1, 16'sd7, 1'b1, 1'b0);
        repeat (3) step(1'b0, 16'sd0, 1'b0, 1'b0);

        // 20 back-to-back samples
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 22; i++) begin
            rd = 16'($urandom);
            step(i < 20, rd, 1'b0, 1'b0);
            if (i < 20 && in_ready) cnt_a++;
            if (out_valid) cnt_b++;
        end
        check_eq("stream_ready", cnt_a, 20);
        check_eq("stream_out_valid", cnt_b, 20);

        // Randomized traffic with held mode requests
        for (int i = 0; i < 800; i++) begin
            if (!hold_v && ($urandom_range(0, 11) == 0)) begin
                hold_v = 1'b1;
                hold_m = 1'($urandom);
            end
            rd = 16'($urandom);
            step(1'($urandom), rd, hold_v, hold_m);
            if (last_racc) hold_v = 1'b0;
        end
        repeat (10) step(1'b0, 16'sd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
